// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// State encoding, default widths and a clog2 helper.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enable-gated binary to one-hot decoder.
// All outputs are low when en is low.
module onehot_decoder #(
    parameter int IN_WIDTH = 5
) (
    input  logic [IN_WIDTH-1:0]      in,
    input  logic                     en,
    output logic [2**IN_WIDTH-1:0]   out
);

    // Raise exactly one output bit when enabled.
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end else begin
            out = '0;
        end
    end

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file with N read ports and a sequenced bulk-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes onto read ports.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clock,
    input  logic                             ctrl_reset,
    input  logic                             ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]            data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg,
    input  logic                             ctrl_clear,
    output logic                             ctrl_busy,
    output logic                             err_wr_drop
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = (ZERO_REG != 0) ? ADDR_WIDTH'(32'd1) : '0;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic                    err_q, err_d;
    logic                    busy_s;
    logic                    wr_en_s;
    logic                    wr_accept_s;
    logic [NUM_REGS-1:0]     dec_s;
    logic [NUM_REGS-1:0]     wr_sel_s;

    assign busy_s  = (state_q == ST_CLEAR);
    assign wr_en_s = ctrl_writeEnable & ~busy_s;

    onehot_decoder #(
        .IN_WIDTH (ADDR_WIDTH)
    ) u_wr_dec (
        .in  (ctrl_writeReg),
        .en  (wr_en_s),
        .out (dec_s)
    );

    // Mask the hardwired zero register out of the write select.
    always_comb begin
        wr_sel_s = dec_s;
        if (ZERO_REG != 0) begin
            wr_sel_s[0] = 1'b0;
        end else begin
            wr_sel_s = dec_s;
        end
        wr_accept_s = |wr_sel_s;
    end

    // Clear sweep sequencing; a clear request during the sweep is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = ctrl_writeEnable & busy_s;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = FIRST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(32'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next storage contents: sweep clear has priority, writes only land when idle.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (busy_s && (cnt_q == ADDR_WIDTH'(i))) begin
                regs_d[i] = '0;
            end else if (wr_sel_s[i]) begin
                regs_d[i] = data_writeReg;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // State, counter, storage and error pulse registers.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign ctrl_busy   = busy_s;
    assign err_wr_drop = err_q;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rd_s;

        assign ra_s = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Combinational read with optional write-through forwarding.
        always_comb begin
            if ((ZERO_REG != 0) && (ra_s == '0)) begin
                rd_s = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_accept_s && (ra_s == ctrl_writeReg)) begin
                rd_s = data_writeReg;
`endif
            end else begin
                rd_s = regs_q[ra_s];
            end
        end

        assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rd_s;
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_accept_s;
    assign unused_accept_s = wr_accept_s;
`endif

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised register file: configurable data width, register count (2**ADDR_WIDTH) and read-port count.
- Internally uses a generic one-hot write-address decoder.
- Adds a sequenced bulk-clear engine with busy status.
- Sits in the processor datapath between decode and execute; successor to the fixed 32x32, two-read-port register file.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address bits; NUM_REGS = 2**ADDR_WIDTH (derived localparam)
NUM_READ, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and unwritable; 0 = ordinary register

Ports:
clock  input  1  system clock, all state updates on rising edge
ctrl_reset  input  1  asynchronous, active-high reset
ctrl_writeEnable  input  1  write request this cycle
ctrl_writeReg  input  ADDR_WIDTH  write address
data_writeReg  input  DATA_WIDTH  write data
ctrl_readReg  input  NUM_READ*ADDR_WIDTH  read addresses, port k at slice [k*ADDR_WIDTH +: ADDR_WIDTH]
data_readReg  output  NUM_READ*DATA_WIDTH  read data, port k at slice [k*DATA_WIDTH +: DATA_WIDTH]
ctrl_clear  input  1  start bulk clear (level sampled in IDLE)
ctrl_busy  output  1  high while clear sweep active
err_wr_drop  output  1  one-cycle pulse: a write was dropped because busy

Behaviour:
- Reset (async, active-high; one clock, named clock):
  - All registers become 0; FSM to IDLE; sweep counter 0.
  - ctrl_busy = 0, err_wr_drop = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Write:
  - Decoder produces a one-hot NUM_REGS vector from ctrl_writeReg, gated by ctrl_writeEnable & ~ctrl_busy.
  - The selected register loads data_writeReg at the rising edge; one-cycle write latency.
  - ZERO_REG=1 and ctrl_writeReg=0: write silently discarded, no error pulse.
- Read:
  - Combinational, zero latency, per port: data = reg[addr].
  - ZERO_REG=1: address 0 always reads 0.
  - Multiple ports may read the same address.
- FSM states IDLE, CLEAR:
  - IDLE & ctrl_clear -> CLEAR. Sweep counter starts at 1 if ZERO_REG else 0; ctrl_busy goes high the next cycle.
  - CLEAR: each cycle reg[counter] <= 0, counter++.
  - When counter == NUM_REGS-1 is cleared, the next state is IDLE and ctrl_busy drops.
  - Sweep length is NUM_REGS-ZERO_REG cycles.
  - ctrl_clear asserted in CLEAR is ignored; no restart.
- Simultaneous events:
  - ctrl_clear with a write in IDLE: the write commits at that edge, then the sweep clears it.
  - Write while ctrl_busy: dropped; err_wr_drop pulses (registered) on the following cycle.
  - Reads during CLEAR return current storage, so registers may be partially cleared.
- Counter width is ADDR_WIDTH; it does not wrap past NUM_REGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address matches an accepted write in the same cycle returns data_writeReg (write-through forwarding).
  - Forwarding never applies to address 0 when ZERO_REG=1.
  - Forwarding never applies to writes dropped while busy.
- Undefined: reads return the pre-edge stored value; the new value is visible the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - FSM state encoding (IDLE=0, CLEAR=1).
  - Default width constants (DATA_WIDTH=32, ADDR_WIDTH=5).
  - Function clog2 for bench use.
- Sub-module onehot_decoder (parameter IN_WIDTH; ports in, en, out[2**IN_WIDTH]): parametrised enable-gated decoder. Instantiated once for the write path.

Test Plan:
- Reset then read all 32 regs on both ports -> all 0x00000000; ctrl_busy=0.
- Write 0xDEADBEEF to reg 7, next cycle read port0=7, port1=7 -> both 0xDEADBEEF.
- Write 0x12345678 to reg 0 (ZERO_REG=1) -> reads 0; err_wr_drop stays 0.
- Fill regs 1..31 with index value, pulse ctrl_clear:
  - ctrl_busy high for exactly 31 cycles.
  - Write to reg 3 mid-sweep -> err_wr_drop pulses once; final reads all 0.
- Assert ctrl_reset at sweep cycle 10 -> ctrl_busy 0 immediately; all regs 0; a new clear afterwards runs the full 31 cycles.
- With REGFILE_BYPASS_EN: write 0xA5A5A5A5 to reg 9 while port1 reads 9 -> port1 shows 0xA5A5A5A5 the same cycle. Without the macro -> old value, new value the next cycle.
